// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier family (shift-add now, radix-4 later).
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mult_state_t;

    localparam int MAX_WIDTH = 128;

    // Counter width able to hold 0..width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_seq.sv
// Multi-cycle shift-add multiplier: one multiplier bit per cycle on operand magnitudes,
// sign applied in a final FIX cycle. Latency is data-independent.
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 data_ok,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CNT_W = cnt_width(WIDTH);

    mult_state_t          state_reg;
    mult_state_t          state_next;

    logic [2*WIDTH-1:0]   acc_reg;
    logic [2*WIDTH-1:0]   x_reg;
    logic [2*WIDTH-1:0]   result_reg;
    logic [WIDTH-1:0]     y_reg;
    logic [CNT_W-1:0]     count_reg;
    logic                 neg_reg;
    logic                 data_ok_reg;

    logic                 xs;
    logic                 ys;
    logic [WIDTH-1:0]     x_mag;
    logic [WIDTH-1:0]     y_mag;
    logic                 last_bit;

    // The most negative operand negates to 2^(WIDTH-1), which is still a valid unsigned magnitude.
    assign xs       = x[WIDTH-1] & is_signed;
    assign ys       = y[WIDTH-1] & is_signed;
    assign x_mag    = xs ? -x : x;
    assign y_mag    = ys ? -y : y;
    assign last_bit = (count_reg == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last_bit) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_reg != IDLE);
        data_ok = data_ok_reg;
        result  = result_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg     <= '0;
            x_reg       <= '0;
            y_reg       <= '0;
            count_reg   <= '0;
            neg_reg     <= 1'b0;
            result_reg  <= '0;
            data_ok_reg <= 1'b0;
        end else begin
            data_ok_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        x_reg     <= {{WIDTH{1'b0}}, x_mag};
                        y_reg     <= y_mag;
                        acc_reg   <= '0;
                        count_reg <= '0;
                        neg_reg   <= xs ^ ys;
                    end
                end
                CALC: begin
                    if (y_reg[0]) begin
                        acc_reg <= acc_reg + x_reg;
                    end
                    x_reg     <= x_reg << 1;
                    y_reg     <= y_reg >> 1;
                    count_reg <= count_reg + CNT_W'(1);
                end
                FIX: begin
                    result_reg  <= neg_reg ? -acc_reg : acc_reg;
                    data_ok_reg <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
